// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes, ALUOp codes.
package cu_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CODE_W  = 2;

    // FSM state encodings, visible on output_State
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_DECODE = 3'd1;
    localparam logic [STATE_W-1:0] ST_EXEC   = 3'd2;
    localparam logic [STATE_W-1:0] ST_MEM    = 3'd3;
    localparam logic [STATE_W-1:0] ST_WB     = 3'd4;
    localparam logic [STATE_W-1:0] ST_FAULT  = 3'd5;

    // Legal opcodes occupy the low two bits; anything set above bit 1 is illegal
    localparam logic [CODE_W-1:0] OP_R   = 2'd0;
    localparam logic [CODE_W-1:0] OP_LW  = 2'd1;
    localparam logic [CODE_W-1:0] OP_SW  = 2'd2;
    localparam logic [CODE_W-1:0] OP_BEQ = 2'd3;

    // ALUOp codes, zero-extended to the configured ALUOp width
    localparam logic [CODE_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [CODE_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [CODE_W-1:0] ALUOP_FUNCT = 2'b10;

    // True for the opcodes that go through the MEM state
    function automatic logic is_mem_op(input logic [CODE_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for the MEM state; expire_c flags the cycle in which
// the count would reach MEM_WAIT_MAX (never when MEM_WAIT_MAX is 0).
module mem_wait_timer #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CNT_W = (MEM_WAIT_MAX == 0) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam int unsigned SAT   = (MEM_WAIT_MAX == 0) ? 1 : MEM_WAIT_MAX;
    localparam logic [CNT_W-1:0] SAT_V  = CNT_W'(SAT);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(SAT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise count up and hold at the limit
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != SAT_V)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Expiry is seen in the same cycle the final increment happens
    always_comb begin
        expire_c = 1'b0;
        if ((MEM_WAIT_MAX != 0) && enable && (count_q >= LAST_V)) begin
            expire_c = 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences IDLE/DECODE/EXEC/MEM/WB, decodes datapath
// strobes from the registered state and latched opcode, stalls on memory ready
// with a timeout, and parks in a sticky FAULT on illegal opcodes or timeouts.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned OP_W         = 2,
    parameter int unsigned ALUOP_W      = 2,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic               input_Clock,
    input  logic               input_Reset,
    input  logic               input_InstrValid,
    input  logic [OP_W-1:0]    input_Operator,
    input  logic               input_Zero,
    input  logic               input_MemReady,
    output logic               output_InstrAccept,
    output logic               output_RegDst,
    output logic               output_RegWrite,
    output logic               output_ALUSrc,
    output logic               output_Branch,
    output logic               output_MemRead,
    output logic               output_MemWrite,
    output logic               output_MemtoReg,
    output logic [ALUOP_W-1:0] output_ALUOp,
    output logic               output_Done,
    output logic               output_Fault,
    output logic [2:0]         output_State
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [OP_W-1:0]    opcode_q;
    logic [OP_W-1:0]    opcode_d;
    logic [CODE_W-1:0]  op_code;
    logic               op_legal;
    logic               timer_clear;
    logic               timer_enable;
    logic               timer_expire_c;

    assign op_code      = opcode_q[CODE_W-1:0];
    assign op_legal     = ((opcode_q >> CODE_W) == '0);
    assign output_State = state_q;

    mem_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_mem_wait_timer (
        .clk      (input_Clock),
        .rst      (input_Reset),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .expire_c (timer_expire_c)
    );

    // Next-state and per-state strobe decode
    always_comb begin
        state_d            = state_q;
        opcode_d           = opcode_q;
        timer_clear        = 1'b0;
        timer_enable       = 1'b0;
        output_InstrAccept = 1'b0;
        output_RegDst      = 1'b0;
        output_RegWrite    = 1'b0;
        output_ALUSrc      = 1'b0;
        output_Branch      = 1'b0;
        output_MemRead     = 1'b0;
        output_MemWrite    = 1'b0;
        output_MemtoReg    = 1'b0;
        output_ALUOp       = ALUOP_W'(ALUOP_ADD);
        output_Done        = 1'b0;
        output_Fault       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                output_InstrAccept = 1'b1;
                if (input_InstrValid) begin
                    opcode_d = input_Operator;
                    state_d  = ST_DECODE;
                end
            end

            ST_DECODE: begin
                state_d = op_legal ? ST_EXEC : ST_FAULT;
            end

            ST_EXEC: begin
                if (is_mem_op(op_code)) begin
                    output_ALUSrc = 1'b1;
                    output_ALUOp  = ALUOP_W'(ALUOP_ADD);
                    timer_clear   = 1'b1;
                    state_d       = ST_MEM;
                end else if (op_code == OP_BEQ) begin
                    output_ALUOp  = ALUOP_W'(ALUOP_SUB);
                    output_Branch = input_Zero;
                    output_Done   = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    output_ALUOp  = ALUOP_W'(ALUOP_FUNCT);
                    state_d       = ST_WB;
                end
            end

            ST_MEM: begin
                output_ALUSrc   = 1'b1;
                output_MemRead  = (op_code == OP_LW);
                output_MemWrite = (op_code == OP_SW);
                if (input_MemReady) begin
                    // Ready beats a simultaneous timeout
                    if (op_code == OP_LW) begin
                        state_d = ST_WB;
                    end else begin
                        output_Done = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else begin
                    timer_enable = 1'b1;
                    if (timer_expire_c) begin
                        state_d = ST_FAULT;
                    end
                end
            end

            ST_WB: begin
                output_RegWrite = 1'b1;
                output_Done     = 1'b1;
                output_RegDst   = (op_code == OP_R);
                output_MemtoReg = (op_code == OP_LW);
                state_d         = ST_IDLE;
            end

            ST_FAULT: begin
                output_Fault = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and opcode registers
    always_ff @(posedge input_Clock or posedge input_Reset) begin
        if (input_Reset) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (OP_W = 4, MEM_WAIT_MAX = 15).
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [3:0] oper;
    logic       zero;
    logic       ready;

    logic       accept, reg_dst, reg_write, alu_src, branch;
    logic       mem_read, mem_write, mem_to_reg, done, fault;
    logic [1:0] alu_op;
    logic [2:0] state;

    logic [14:0] obs;
    logic [14:0] expv;
    int          nvec = 0;
    int          nerr = 0;

    // {accept, regdst, regwrite, alusrc, branch, memread, memwrite, memtoreg, aluop, done, fault, state}
    localparam logic [14:0] V_IDLE        = {1'b1, 7'b0000000, 2'b00, 2'b00, 3'd0};
    localparam logic [14:0] V_DEC         = {1'b0, 7'b0000000, 2'b00, 2'b00, 3'd1};
    localparam logic [14:0] V_EXEC_R      = {1'b0, 7'b0000000, 2'b10, 2'b00, 3'd2};
    localparam logic [14:0] V_WB_R        = {1'b0, 3'b110, 4'b0000, 2'b00, 2'b10, 3'd4};
    localparam logic [14:0] V_EXEC_MEM    = {1'b0, 3'b001, 4'b0000, 2'b00, 2'b00, 3'd2};
    localparam logic [14:0] V_MEM_LW      = {1'b0, 3'b001, 4'b0100, 2'b00, 2'b00, 3'd3};
    localparam logic [14:0] V_MEM_SW      = {1'b0, 3'b001, 4'b0010, 2'b00, 2'b00, 3'd3};
    localparam logic [14:0] V_MEM_SW_DONE = {1'b0, 3'b001, 4'b0010, 2'b00, 2'b10, 3'd3};
    localparam logic [14:0] V_WB_LW       = {1'b0, 3'b010, 4'b0001, 2'b00, 2'b10, 3'd4};
    localparam logic [14:0] V_FAULT       = {1'b0, 7'b0000000, 2'b00, 2'b01, 3'd5};

    always #5 clk = ~clk;

    assign obs = {accept, reg_dst, reg_write, alu_src, branch, mem_read, mem_write,
                  mem_to_reg, alu_op, done, fault, state};

    multicycle_control_unit #(
        .OP_W         (4),
        .ALUOP_W      (2),
        .MEM_WAIT_MAX (15)
    ) dut (
        .input_Clock        (clk),
        .input_Reset        (rst),
        .input_InstrValid   (valid),
        .input_Operator     (oper),
        .input_Zero         (zero),
        .input_MemReady     (ready),
        .output_InstrAccept (accept),
        .output_RegDst      (reg_dst),
        .output_RegWrite    (reg_write),
        .output_ALUSrc      (alu_src),
        .output_Branch      (branch),
        .output_MemRead     (mem_read),
        .output_MemWrite    (mem_write),
        .output_MemtoReg    (mem_to_reg),
        .output_ALUOp       (alu_op),
        .output_Done        (done),
        .output_Fault       (fault),
        .output_State       (state)
    );

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; oper = 4'h0; zero = 1'b0; ready = 1'b0;
        cyc(); cyc(); #1;
        nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL reset_held: got %h want %h", obs, V_IDLE); end
        rst = 1'b0;
        cyc(); #1;
        nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL reset_release: got %h want %h", obs, V_IDLE); end
    endtask

    task automatic test_r_type();
        valid = 1'b1; oper = 4'h0; #1;
        nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL r_accept: got %h want %h", obs, V_IDLE); end
        cyc(); valid = 1'b0; oper = 4'h3; #1;
        nvec++; if (obs !== V_DEC) begin nerr++; $display("FAIL r_decode: got %h want %h", obs, V_DEC); end
        cyc(); #1;
        nvec++; if (obs !== V_EXEC_R) begin nerr++; $display("FAIL r_exec: got %h want %h", obs, V_EXEC_R); end
        cyc(); #1;
        nvec++; if (obs !== V_WB_R) begin nerr++; $display("FAIL r_wb: got %h want %h", obs, V_WB_R); end
        cyc(); #1;
        nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL r_idle: got %h want %h", obs, V_IDLE); end
    endtask

    task automatic test_lw();
        valid = 1'b1; oper = 4'h1; #1;
        nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL lw_accept: got %h want %h", obs, V_IDLE); end
        cyc(); valid = 1'b0; oper = 4'h2; #1;
        nvec++; if (obs !== V_DEC) begin nerr++; $display("FAIL lw_decode: got %h want %h", obs, V_DEC); end
        cyc(); #1;
        nvec++; if (obs !== V_EXEC_MEM) begin nerr++; $display("FAIL lw_exec: got %h want %h", obs, V_EXEC_MEM); end
        for (int i = 0; i < 4; i++) begin
            cyc(); ready = (i == 3); #1;
            nvec++; if (obs !== V_MEM_LW) begin nerr++; $display("FAIL lw_mem%0d: got %h want %h", i, obs, V_MEM_LW); end
        end
        cyc(); ready = 1'b0; #1;
        nvec++; if (obs !== V_WB_LW) begin nerr++; $display("FAIL lw_wb: got %h want %h", obs, V_WB_LW); end
        cyc(); #1;
        nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL lw_idle: got %h want %h", obs, V_IDLE); end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            valid = 1'b1; oper = 4'h3; #1;
            nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL beq_accept z=%0d: got %h want %h", z, obs, V_IDLE); end
            cyc(); valid = 1'b0; oper = 4'h0; #1;
            nvec++; if (obs !== V_DEC) begin nerr++; $display("FAIL beq_decode z=%0d: got %h want %h", z, obs, V_DEC); end
            cyc(); zero = 1'(z); #1;
            expv = {1'b0, 3'b000, 1'(z), 3'b000, 2'b01, 2'b10, 3'd2};
            nvec++; if (obs !== expv) begin nerr++; $display("FAIL beq_exec z=%0d: got %h want %h", z, obs, expv); end
            zero = ~1'(z); #1;
            expv = {1'b0, 3'b000, ~1'(z), 3'b000, 2'b01, 2'b10, 3'd2};
            nvec++; if (obs !== expv) begin nerr++; $display("FAIL beq_live z=%0d: got %h want %h", z, obs, expv); end
            cyc(); zero = 1'b0; #1;
            nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL beq_idle z=%0d: got %h want %h", z, obs, V_IDLE); end
        end
    endtask

    // ready_at = 0: never ready (expect timeout), else ready in that MEM cycle
    task automatic test_sw(input int ready_at);
        valid = 1'b1; oper = 4'h2; #1;
        nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL sw_accept: got %h want %h", obs, V_IDLE); end
        cyc(); valid = 1'b0; #1;
        nvec++; if (obs !== V_DEC) begin nerr++; $display("FAIL sw_decode: got %h want %h", obs, V_DEC); end
        cyc(); #1;
        nvec++; if (obs !== V_EXEC_MEM) begin nerr++; $display("FAIL sw_exec: got %h want %h", obs, V_EXEC_MEM); end
        for (int i = 1; i <= 15; i++) begin
            cyc(); ready = (i == ready_at); #1;
            expv = ready ? V_MEM_SW_DONE : V_MEM_SW;
            nvec++; if (obs !== expv) begin nerr++; $display("FAIL sw_mem%0d: got %h want %h", i, obs, expv); end
        end
        cyc(); ready = 1'b0; valid = 1'b1; #1;
        expv = (ready_at == 0) ? V_FAULT : V_IDLE;
        nvec++; if (obs !== expv) begin nerr++; $display("FAIL sw_after: got %h want %h", obs, expv); end
        valid = 1'b0;
        if (ready_at == 0) begin
            valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                cyc(); #1;
                nvec++; if (obs !== V_FAULT) begin nerr++; $display("FAIL sw_sticky%0d: got %h want %h", i, obs, V_FAULT); end
            end
            valid = 1'b0; rst = 1'b1; #1;
            nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL sw_recover: got %h want %h", obs, V_IDLE); end
            cyc(); rst = 1'b0; #1;
        end
    endtask

    task automatic test_illegal();
        valid = 1'b1; oper = 4'b0101; #1;
        nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL ill_accept: got %h want %h", obs, V_IDLE); end
        cyc(); valid = 1'b0; oper = 4'h0; #1;
        nvec++; if (obs !== V_DEC) begin nerr++; $display("FAIL ill_decode: got %h want %h", obs, V_DEC); end
        cyc(); #1;
        nvec++; if (obs !== V_FAULT) begin nerr++; $display("FAIL ill_fault: got %h want %h", obs, V_FAULT); end
        rst = 1'b1; #1;
        nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL ill_recover: got %h want %h", obs, V_IDLE); end
        cyc(); rst = 1'b0; #1;
    endtask

    task automatic test_reset_mid_lw();
        valid = 1'b1; oper = 4'h1; #1;
        cyc(); valid = 1'b0; #1;
        cyc(); #1;
        cyc(); ready = 1'b0; #1;
        nvec++; if (obs !== V_MEM_LW) begin nerr++; $display("FAIL midrst_mem: got %h want %h", obs, V_MEM_LW); end
        #2; rst = 1'b1; #1;
        nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL midrst_abort: got %h want %h", obs, V_IDLE); end
        cyc(); rst = 1'b0; #1;
        nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL midrst_after: got %h want %h", obs, V_IDLE); end
    endtask

    task automatic test_back_to_back();
        valid = 1'b1; oper = 4'h0; #1;
        cyc(); valid = 1'b0; #1;
        cyc(); #1;
        cyc(); #1;
        nvec++; if (obs !== V_WB_R) begin nerr++; $display("FAIL b2b_wb: got %h want %h", obs, V_WB_R); end
        cyc(); valid = 1'b1; oper = 4'h3; #1;
        nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL b2b_accept: got %h want %h", obs, V_IDLE); end
        cyc(); valid = 1'b0; #1;
        nvec++; if (obs !== V_DEC) begin nerr++; $display("FAIL b2b_decode: got %h want %h", obs, V_DEC); end
        cyc(); zero = 1'b0; #1;
        expv = {1'b0, 7'b0000000, 2'b01, 2'b10, 3'd2};
        nvec++; if (obs !== expv) begin nerr++; $display("FAIL b2b_exec: got %h want %h", obs, expv); end
        cyc(); #1;
        nvec++; if (obs !== V_IDLE) begin nerr++; $display("FAIL b2b_idle: got %h want %h", obs, V_IDLE); end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_lw();
        test_beq();
        test_sw(0);
        test_sw(15);
        test_illegal();
        test_reset_mid_lw();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle successor to the single-cycle opcode decoder. Sequences each instruction through IDLE/DECODE/EXEC/MEM/WB, drives the datapath control strobes per state, and stalls on a memory-ready handshake with timeout. Sits between the instruction register and the datapath. Illegal opcodes and memory timeouts park it in a sticky FAULT state.

## Interface
- OP_W, 2, opcode width; must be ≥2.
- ALUOP_W, 2, ALUOp width; must be ≥2.
- MEM_WAIT_MAX, 15, maximum cycles spent in MEM waiting for ready; 0 disables the timeout.

Ports:
- input_Clock  in  1  single clock, rising edge.
- input_Reset  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- input_InstrValid  in  1  instruction available on input_Operator.
- input_Operator  in  OP_W  opcode; sampled only on acceptance.
- input_Zero  in  1  ALU zero flag, used for branch.
- input_MemReady  in  1  memory completes the current access.
- output_InstrAccept  out  1  high in IDLE only.
- output_RegDst, output_RegWrite, output_ALUSrc, output_Branch, output_MemRead, output_MemWrite, output_MemtoReg  out  1 each  datapath strobes.
- output_ALUOp  out  ALUOP_W  00 = ADD, 01 = SUB, 10 = FUNCT, zero-extended.
- output_Done  out  1  one-cycle pulse in the last cycle of an instruction.
- output_Fault  out  1  high in FAULT.
- output_State  out  3  current state encoding.

## Operation
- Opcodes are R = 0, LW = 1, SW = 2, BEQ = 3. Any opcode with a nonzero bit above bit 1 is illegal.
- IDLE: InstrAccept = 1. If InstrValid is high, latch the opcode and go to DECODE. Otherwise stay.
- DECODE: all strobes 0. Illegal opcode → FAULT; otherwise → EXEC.
- EXEC:
  - R: ALUOp = FUNCT, → WB.
  - LW/SW: ALUSrc = 1, ALUOp = ADD, clear wait counter, → MEM.
  - BEQ: ALUOp = SUB, Branch = input_Zero (combinational), Done = 1, → IDLE.
- MEM:
  - LW: MemRead = 1, ALUSrc = 1.
  - SW: MemWrite = 1, ALUSrc = 1.
  - On MemReady: LW → WB; SW pulses Done and → IDLE.
  - Otherwise increment the counter. If the counter reaches MEM_WAIT_MAX (and MEM_WAIT_MAX ≠ 0), → FAULT.
  - If MemReady and counter expiry occur in the same cycle, MemReady wins.
- WB: RegWrite = 1, Done = 1, → IDLE.
  - R: RegDst = 1.
  - LW: MemtoReg = 1.
- FAULT: all strobes 0, Fault = 1, InstrAccept = 0. Sticky until reset.
- Strobes are decoded from the registered state and latched opcode. Only Branch depends on a live input.

## Timing
- Reset values: State = IDLE, InstrAccept = 1, every other output 0, opcode register 0, counter 0.
- Reset asserted mid-instruction aborts immediately, with no Done pulse. MemRead/MemWrite drop asynchronously.
- Latency, accept cycle to Done cycle inclusive:
  - R: 4.
  - BEQ: 3.
  - LW: 4 + n.
  - SW: 3 + n.
  - n is the number of MEM cycles; n ≥ 1, and ready in the first MEM cycle gives n = 1.
- Back-to-back: the cycle after Done is IDLE, so the next accept is at Done + 1.
- The counter is $clog2(MEM_WAIT_MAX+1) bits wide and saturates. It never wraps.
- input_Operator changes after acceptance have no effect.

## Structure
- Shared package `cu_pkg` holds:
  - state encodings (IDLE = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, FAULT = 5);
  - opcode constants;
  - ALUOp codes.
- One sub-module, `mem_wait_timer`: clear, enable, and expire output, parametrised by MEM_WAIT_MAX.
- The FSM and output decode live in the top module.

## Test plan
- Reset, then R opcode 00 with InstrValid → DECODE, EXEC (ALUOp = 10), WB (RegWrite = 1, RegDst = 1, Done = 1), IDLE; 4 cycles total.
- LW with MemReady held low 3 cycles, then high → MemRead = 1 for 4 cycles, then WB with MemtoReg = 1 and RegWrite = 1, Done pulse; 8 cycles total.
- BEQ with input_Zero = 1, then with input_Zero = 0 → Branch follows Zero in EXEC, ALUOp = 01, Done in cycle 3.
- SW with MemReady never asserted, MEM_WAIT_MAX = 15 → MemWrite high 15 cycles, then FAULT with Fault = 1 held. Repeat with ready on cycle 15 → IDLE, no fault.
- OP_W = 4, opcode 4'b0101 → FAULT after DECODE with no strobes. Assert reset mid-LW in MEM → all outputs 0 and InstrAccept = 1 immediately.
